// File: rtl/uart_transmitter_if.sv
// Handshake and serial-line bundle for uart_transmitter.
// master drives the request side; slave is the transmitter itself.
interface uart_transmitter_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] data_in;
  logic                 tx_ready;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 tx;

  modport master (
    output tx_start, data_in,
    input  tx_ready, tx_busy, tx_done, tx
  );

  modport slave (
    input  tx_start, data_in,
    output tx_ready, tx_busy, tx_done, tx
  );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter with a one-deep holding register in front of the shifter; MSB-first frames.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_transmitter #(
  parameter int DATA_BITS     = 8,
  parameter int STOP_BIT_TICK = 16
) (
  input  logic            clk_50MHz,
  input  logic            reset,
  input  logic            sample_tick,
  uart_transmitter_if.slave bus
);

  localparam int TW = (STOP_BIT_TICK > 1) ? $clog2(STOP_BIT_TICK) : 1;
  localparam int BW = $clog2(DATA_BITS) + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic accept;
  logic tick_end;

  assign accept   = bus.tx_start && !hold_valid_q;
  assign tick_end = sample_tick && (tick_q == TW'(STOP_BIT_TICK - 1));

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    tx_d         = tx_q;
    done_d       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif

    // accept and the idle load are mutually exclusive: a load needs hold_valid_q=1, accept needs 0
    if (accept) begin
      hold_data_d  = bus.data_in;
      hold_valid_d = 1'b1;
    end

    if (state_q != S_IDLE && sample_tick) begin
      tick_d = tick_end ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        tick_d = '0;
        if (hold_valid_q) begin
          shift_d      = hold_data_q;
          hold_valid_d = 1'b0;
          tx_d         = 1'b0;
          bit_d        = '0;
          state_d      = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d     = ^hold_data_q;
`endif
        end
      end

      S_START: begin
        if (tick_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[DATA_BITS-1];
        end
      end

      S_DATA: begin
        if (tick_end) begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d = shift_q << 1;
            tx_d    = shift_d[DATA_BITS-1];
            bit_d   = bit_q + 1'b1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        tx_d = 1'b1;
        if (tick_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign bus.tx_ready = ~hold_valid_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_done  = done_q;
  assign bus.tx       = tx_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a line monitor decodes frames by mid-bit sampling.
module tb_uart_transmitter;

  localparam int DB = 8;
  localparam int SBT = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME_TICKS = (2 + DB + PAR) * SBT;

  logic clk_50MHz;
  logic reset;
  logic sample_tick;

  uart_transmitter_if #(.DATA_BITS(DB)) bus ();

  uart_transmitter #(.DATA_BITS(DB), .STOP_BIT_TICK(SBT)) dut (
    .clk_50MHz  (clk_50MHz),
    .reset      (reset),
    .sample_tick(sample_tick),
    .bus        (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int tick_count = 0;
  int cyc = 0;

  int fall_cyc_q[$];
  int fall_tick_q[$];
  int done_cyc_q[$];
  int done_tick_q[$];
  int word_q[$];
  int ok_q[$];
  int par_q[$];
  int done_wide = 0;

  initial begin
    clk_50MHz = 1'b0;
    forever #10 clk_50MHz = ~clk_50MHz;
  end

  initial begin
    int div;
    div = 0;
    sample_tick = 1'b0;
    forever begin
      @(negedge clk_50MHz);
      div = (div == 26) ? 0 : div + 1;
      sample_tick = (div == 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk_50MHz);
      cyc = cyc + 1;
      if (sample_tick) tick_count = tick_count + 1;
    end
  end

  // Line monitor: frame starts at a falling edge, bits sampled 8 ticks into each period
  initial begin
    bit mon_active;
    bit done_prev;
    int mon_target;
    int mon_idx;
    int mon_ok;
    int mon_par;
    logic [DB-1:0] mon_word;
    mon_active = 0;
    done_prev  = 0;
    mon_target = 0;
    mon_idx    = 0;
    mon_ok     = 0;
    mon_par    = 0;
    mon_word   = '0;
    forever begin
      @(negedge clk_50MHz);
      if (reset) begin
        mon_active = 0;
        done_prev  = 0;
      end else begin
        if (bus.tx_done === 1'b1) begin
          done_cyc_q.push_back(cyc);
          done_tick_q.push_back(tick_count);
          if (done_prev) done_wide = done_wide + 1;
        end
        done_prev = (bus.tx_done === 1'b1);
        if (!mon_active) begin
          if (bus.tx === 1'b0) begin
            mon_active = 1;
            mon_target = tick_count + SBT / 2;
            mon_idx    = 0;
            mon_ok     = 1;
            mon_word   = '0;
            fall_cyc_q.push_back(cyc);
            fall_tick_q.push_back(tick_count);
          end
        end else if (tick_count >= mon_target) begin
          if (mon_idx == 0) begin
            if (bus.tx !== 1'b0) mon_ok = 0;
          end else if (mon_idx <= DB) begin
            mon_word = {mon_word[DB-2:0], bus.tx};
          end else if (PAR == 1 && mon_idx == DB + 1) begin
            mon_par = int'(bus.tx);
          end else begin
            if (bus.tx !== 1'b1) mon_ok = 0;
            word_q.push_back(int'(mon_word));
            ok_q.push_back(mon_ok);
            par_q.push_back(mon_par);
            mon_active = 0;
          end
          mon_idx    = mon_idx + 1;
          mon_target = mon_target + SBT;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [DB-1:0] d);
    @(negedge clk_50MHz);
    bus.tx_start = 1'b1;
    bus.data_in  = d;
    @(negedge clk_50MHz);
    bus.tx_start = 1'b0;
  endtask

  task automatic wait_done(input int n, input string tag);
    int k;
    k = 0;
    while (done_cyc_q.size() < n && k < 8000) begin
      @(negedge clk_50MHz);
      k++;
    end
    chk(tag, 32'(done_cyc_q.size() >= n), 32'd1);
  endtask

  task automatic wait_ticks(input int n);
    int t;
    t = tick_count + n;
    while (tick_count < t) @(negedge clk_50MHz);
  endtask

  initial begin
    int t0;
    int k;
    int nd;
    logic tx_all_high;
    logic [7:0] lb [3];
    lb[0] = 8'h00;
    lb[1] = 8'hFF;
    lb[2] = 8'h5A;

    reset        = 1'b1;
    bus.tx_start = 1'b1;
    bus.data_in  = 8'h11;
    repeat (5) @(negedge clk_50MHz);
    chk("reset_tx",    32'(bus.tx),       32'd1);
    chk("reset_busy",  32'(bus.tx_busy),  32'd0);
    chk("reset_done",  32'(bus.tx_done),  32'd0);
    chk("reset_ready", 32'(bus.tx_ready), 32'd1);
    bus.tx_start = 1'b0;
    reset = 1'b0;
    repeat (30) @(negedge clk_50MHz);
    chk("post_reset_idle_tx", 32'(bus.tx), 32'd1);
    chk("post_reset_no_fall", 32'(fall_cyc_q.size()), 32'd0);

    // Single frame 0xA5
    send(8'hA5);
    chk("a5_tx_after_accept",    32'(bus.tx),       32'd1);
    chk("a5_ready_after_accept", 32'(bus.tx_ready), 32'd0);
    @(negedge clk_50MHz);
    chk("a5_tx_start_bit", 32'(bus.tx),       32'd0);
    chk("a5_busy",         32'(bus.tx_busy),  32'd1);
    chk("a5_ready_load",   32'(bus.tx_ready), 32'd1);
    wait_done(1, "a5_done_timeout");
    @(negedge clk_50MHz);
    chk("a5_done_pulse_end", 32'(bus.tx_done), 32'd0);
    chk("a5_busy_after",     32'(bus.tx_busy), 32'd0);
    chk("a5_word",  32'(word_q.size() > 0 ? word_q[0] : -1), 32'h0000_00A5);
    chk("a5_len",   32'(done_tick_q[0] - fall_tick_q[0]), 32'(FRAME_TICKS));

    // Back-to-back frames, third request while holding register full
    repeat (20) @(negedge clk_50MHz);
    send(8'h3C);
    @(negedge clk_50MHz);
    chk("b2b_ready_after_load", 32'(bus.tx_ready), 32'd1);
    wait_ticks(40);
    send(8'hC3);
    chk("b2b_c3_accepted", 32'(bus.tx_ready), 32'd0);
    send(8'hFF);
    chk("b2b_ff_ignored_ready", 32'(bus.tx_ready), 32'd0);
    wait_done(3, "b2b_done_timeout");
    wait_ticks(20);
    chk("b2b_frame_count", 32'(fall_cyc_q.size()), 32'd3);
    chk("b2b_word1", 32'(word_q.size() > 1 ? word_q[1] : -1), 32'h0000_003C);
    chk("b2b_word2", 32'(word_q.size() > 2 ? word_q[2] : -1), 32'h0000_00C3);
    chk("b2b_gap",   32'(fall_cyc_q[2] - done_cyc_q[1]), 32'd1);
    chk("b2b_len2",  32'(done_tick_q[2] - fall_tick_q[2]), 32'(FRAME_TICKS));

    // Reset during the 4th data bit of 0x81, with 0x99 queued behind it
    send(8'h81);
    k = 0;
    while (fall_cyc_q.size() < 4 && k < 100) begin
      @(negedge clk_50MHz);
      k++;
    end
    chk("rst_81_started", 32'(fall_cyc_q.size()), 32'd4);
    t0 = fall_tick_q[fall_cyc_q.size() - 1];
    send(8'h99);
    chk("rst_99_queued", 32'(bus.tx_ready), 32'd0);
    while (tick_count < t0 + 4 * SBT + SBT / 2) @(negedge clk_50MHz);
    nd = done_cyc_q.size();
    reset = 1'b1;
    @(negedge clk_50MHz);
    chk("rst_tx",    32'(bus.tx),       32'd1);
    chk("rst_ready", 32'(bus.tx_ready), 32'd1);
    chk("rst_busy",  32'(bus.tx_busy),  32'd0);
    reset = 1'b0;
    tx_all_high = 1'b1;
    repeat (600) begin
      @(negedge clk_50MHz);
      if (bus.tx !== 1'b1) tx_all_high = 1'b0;
    end
    chk("rst_line_stays_idle", 32'(tx_all_high), 32'd1);
    chk("rst_no_done", 32'(done_cyc_q.size()), 32'(nd));
    send(8'h55);
    wait_done(4, "rst_55_done_timeout");
    @(negedge clk_50MHz);
    chk("rst_55_word", 32'(word_q.size() > 3 ? word_q[3] : -1), 32'h0000_0055);
    chk("rst_55_len",  32'(done_tick_q[3] - fall_tick_q[4]), 32'(FRAME_TICKS));

    // Loopback words decoded by the line monitor
    for (int i = 0; i < 3; i++) begin
      send(lb[i]);
      wait_done(5 + i, "lb_done_timeout");
      @(negedge clk_50MHz);
      chk("lb_word", 32'(word_q.size() > 4 + i ? word_q[4 + i] : -1), 32'(lb[i]));
    end

`ifdef UART_TX_PARITY_EN
    send(8'h07);
    wait_done(8, "par07_done_timeout");
    @(negedge clk_50MHz);
    chk("par07_word", 32'(word_q.size() > 7 ? word_q[7] : -1), 32'h0000_0007);
    chk("par07_bit",  32'(par_q.size() > 7 ? par_q[7] : -1), 32'd1);
    send(8'h03);
    wait_done(9, "par03_done_timeout");
    @(negedge clk_50MHz);
    chk("par03_word", 32'(word_q.size() > 8 ? word_q[8] : -1), 32'h0000_0003);
    chk("par03_bit",  32'(par_q.size() > 8 ? par_q[8] : -1), 32'd0);
    chk("par_len",    32'(done_tick_q[8] - fall_tick_q[9]), 32'(11 * SBT));
`endif

    for (int i = 0; i < ok_q.size(); i++) begin
      chk("frame_start_stop_ok", 32'(ok_q[i]), 32'd1);
    end
    chk("done_single_clock", 32'(done_wide), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
